prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 32 +++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader:
// FSM state encoding and frame field widths.
package prog_loader_pkg;

  localparam int COUNT_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    LOAD   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Shifts payload bytes into big-endian 32-bit words and
// flags the cycle on which the fourth byte arrives.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [31:0]       o_word,
  output logic              o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // Word is presented combinationally so the loader can
  // register it together with address and count.
  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_en & (r_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: frames a byte stream into instruction memory
// writes and releases cpu reset after a verified image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [COUNT_W-1:0]  words_loaded
);

  localparam logic [COUNT_W:0] MAXW = (COUNT_W+1)'(MAX_WORDS);

  state_t               r_state;
  state_t               w_next;
  logic                 r_ready;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_cpu_reset;
  logic                 r_done;
  logic                 r_error;
  logic [COUNT_W-1:0]   r_words;
  logic [COUNT_W-1:0]   r_count;
  logic [BYTE_W-1:0]    r_csum;

  logic                 w_accept;
  logic                 w_pack_en;
  logic [31:0]          w_word;
  logic                 w_word_valid;
  logic [COUNT_W-1:0]   w_hdr_count;
  logic [COUNT_W-1:0]   w_words_inc;

  assign w_accept    = in_valid & r_ready;
  assign w_pack_en   = w_accept & (r_state == LOAD);
  assign w_hdr_count = {r_count[15:8], in_data};
  assign w_words_inc = r_words + 16'd1;

  prog_loader_byte_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .i_en         (w_pack_en),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= HDR_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HDR_HI: if (w_accept) w_next = HDR_LO;
      HDR_LO: begin
        if (w_accept) begin
          if ({1'b0, w_hdr_count} > MAXW) w_next = ERROR;
          else if (w_hdr_count == '0)     w_next = CSUM;
          else                            w_next = LOAD;
        end
      end
      LOAD: begin
        if (w_word_valid && (w_words_inc == r_count))
          w_next = CSUM;
      end
      CSUM: begin
        if (w_accept)
          w_next = (in_data == r_csum) ? DONE : ERROR;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
      r_count     <= '0;
      r_csum      <= '0;
    end else begin
      r_ready <= (w_next != DONE) && (w_next != ERROR);
      r_we    <= w_word_valid;
      if (w_word_valid) begin
        r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
        r_wdata <= w_word;
        r_words <= w_words_inc;
      end
      if (w_accept && r_state == HDR_HI) r_count[15:8] <= in_data;
      if (w_accept && r_state == HDR_LO) r_count[7:0]  <= in_data;
      if (w_pack_en) r_csum <= r_csum ^ in_data;
      if (w_next == DONE) begin
        r_done      <= 1'b1;
        r_cpu_reset <= 1'b0;
      end
      if (w_next == ERROR) r_error <= 1'b1;
    end
  end

  assign in_ready     = r_ready;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance at base 0,
// one at base 0x100 for the stalled/offset load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v   [2];
  logic [7:0]  d   [2];
  logic        rdy [2];
  logic        we  [2];
  logic [31:0] ma  [2];
  logic [31:0] md  [2];
  logic        cr  [2];
  logic        dn  [2];
  logic        er  [2];
  logic [15:0] wl  [2];

  int checks = 0;
  int errors = 0;
  int nw [2];
  int nb [2];

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) u0 (
    .clock(clk), .reset(rst), .in_valid(v[0]), .in_data(d[0]),
    .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(ma[0]),
    .mem_wdata(md[0]), .cpu_reset(cr[0]), .done(dn[0]),
    .error(er[0]), .words_loaded(wl[0])
  );

  prog_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(1024)) u1 (
    .clock(clk), .reset(rst), .in_valid(v[1]), .in_data(d[1]),
    .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(ma[1]),
    .mem_wdata(md[1]), .cpu_reset(cr[1]), .done(dn[1]),
    .error(er[1]), .words_loaded(wl[1])
  );

  initial begin
    nw[0] = 0;
    nw[1] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (we[i] === 1'b1) nw[i] = nw[i] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    @(posedge clk); #1;
    nb[0] = nw[0];
    nb[1] = nw[1];
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input int s, input logic [7:0] b,
                      input int gap);
    logic ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      v[s] = 1'b0;
      @(posedge clk); #1;
    end
    v[s] = 1'b1;
    d[s] = b;
    for (int k = 0; k < 40; k++) begin
      if (rdy[s]) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    v[s] = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    v[0] = 1'b0; v[1] = 1'b0;
    d[0] = 8'h00; d[1] = 8'h00;

    // reset state
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_we", {31'd0, we[0]}, 32'd0);
    chk("rst_addr1", ma[1], 32'h100);
    chk("rst_wdata", md[0], 32'd0);
    chk("rst_cpu_reset", {31'd0, cr[0]}, 32'd1);
    chk("rst_done", {31'd0, dn[0]}, 32'd0);
    chk("rst_error", {31'd0, er[0]}, 32'd0);
    chk("rst_words", {16'd0, wl[0]}, 32'd0);
    nb[0] = nw[0];
    nb[1] = nw[1];
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, rdy[0]}, 32'd1);

    // basic two-word load, payload xor = 0x89
    send(0, 8'h00, 0); send(0, 8'h02, 0);
    send(0, 8'h20, 0); send(0, 8'h08, 0);
    send(0, 8'h00, 0); send(0, 8'h05, 0);
    chk("w0_we", {31'd0, we[0]}, 32'd1);
    chk("w0_addr", ma[0], 32'h0);
    chk("w0_data", md[0], 32'h2008_0005);
    chk("w0_words", {16'd0, wl[0]}, 32'd1);
    chk("w0_ready", {31'd0, rdy[0]}, 32'd1);
    send(0, 8'hAC, 0); send(0, 8'h08, 0);
    send(0, 8'h00, 0); send(0, 8'h00, 0);
    chk("w1_we", {31'd0, we[0]}, 32'd1);
    chk("w1_addr", ma[0], 32'h4);
    chk("w1_data", md[0], 32'hAC08_0000);
    chk("w1_words", {16'd0, wl[0]}, 32'd2);
    send(0, 8'h89, 0);
    chk("ok_done", {31'd0, dn[0]}, 32'd1);
    chk("ok_cpu_reset", {31'd0, cr[0]}, 32'd0);
    chk("ok_ready", {31'd0, rdy[0]}, 32'd0);
    chk("ok_error", {31'd0, er[0]}, 32'd0);
    chk("ok_we", {31'd0, we[0]}, 32'd0);
    chk("ok_nwrites", nw[0] - nb[0], 32'd2);

    // bad checksum
    do_reset();
    send(0, 8'h00, 0); send(0, 8'h02, 0);
    send(0, 8'h20, 0); send(0, 8'h08, 0);
    send(0, 8'h00, 0); send(0, 8'h05, 0);
    send(0, 8'hAC, 0); send(0, 8'h08, 0);
    send(0, 8'h00, 0); send(0, 8'h00, 0);
    send(0, 8'h8D, 0);
    chk("bad_error", {31'd0, er[0]}, 32'd1);
    chk("bad_done", {31'd0, dn[0]}, 32'd0);
    chk("bad_cpu_reset", {31'd0, cr[0]}, 32'd1);
    chk("bad_ready", {31'd0, rdy[0]}, 32'd0);
    chk("bad_nwrites", nw[0] - nb[0], 32'd2);
    v[0] = 1'b1; d[0] = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    v[0] = 1'b0;
    chk("bad_hold_ready", {31'd0, rdy[0]}, 32'd0);
    chk("bad_hold_words", {16'd0, wl[0]}, 32'd2);
    chk("bad_hold_we", {31'd0, we[0]}, 32'd0);

    // oversize header 0x0401
    do_reset();
    send(0, 8'h04, 0); send(0, 8'h01, 0);
    chk("big_error", {31'd0, er[0]}, 32'd1);
    chk("big_ready", {31'd0, rdy[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("big_nwrites", nw[0] - nb[0], 32'd0);

    // max-size header is legal
    do_reset();
    send(0, 8'h04, 0); send(0, 8'h00, 0);
    chk("max_error", {31'd0, er[0]}, 32'd0);
    chk("max_ready", {31'd0, rdy[0]}, 32'd1);

    // zero-length image
    do_reset();
    send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h00, 0);
    chk("zero_done", {31'd0, dn[0]}, 32'd1);
    chk("zero_words", {16'd0, wl[0]}, 32'd0);
    chk("zero_nwrites", nw[0] - nb[0], 32'd0);
    do_reset();
    send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h01, 0);
    chk("zero_bad_error", {31'd0, er[0]}, 32'd1);
    chk("zero_bad_done", {31'd0, dn[0]}, 32'd0);

    // stalls with base 0x100
    do_reset();
    send(1, 8'h00, $urandom_range(0, 3));
    send(1, 8'h01, $urandom_range(0, 3));
    send(1, 8'h12, $urandom_range(0, 3));
    send(1, 8'h34, $urandom_range(0, 3));
    send(1, 8'h56, $urandom_range(0, 3));
    send(1, 8'h78, $urandom_range(0, 3));
    chk("stl_we", {31'd0, we[1]}, 32'd1);
    chk("stl_addr", ma[1], 32'h100);
    chk("stl_data", md[1], 32'h1234_5678);
    send(1, 8'h08, $urandom_range(1, 3));
    chk("stl_done", {31'd0, dn[1]}, 32'd1);
    chk("stl_cpu_reset", {31'd0, cr[1]}, 32'd0);
    chk("stl_nwrites", nw[1] - nb[1], 32'd1);

    // reset mid-load after six payload bytes
    do_reset();
    send(0, 8'h00, 0); send(0, 8'h02, 0);
    send(0, 8'h20, 0); send(0, 8'h08, 0);
    send(0, 8'h00, 0); send(0, 8'h05, 0);
    send(0, 8'hAC, 0); send(0, 8'h08, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_cpu_reset", {31'd0, cr[0]}, 32'd1);
    chk("mid_words", {16'd0, wl[0]}, 32'd0);
    chk("mid_ready", {31'd0, rdy[0]}, 32'd0);
    nb[0] = nw[0];
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h00, 0); send(0, 8'h01, 0);
    send(0, 8'hDE, 0); send(0, 8'hAD, 0);
    send(0, 8'hBE, 0); send(0, 8'hEF, 0);
    chk("mid_w_addr", ma[0], 32'h0);
    chk("mid_w_data", md[0], 32'hDEAD_BEEF);
    chk("mid_w_words", {16'd0, wl[0]}, 32'd1);
    send(0, 8'h22, 0);
    chk("mid_done", {31'd0, dn[0]}, 32'd1);
    chk("mid_nwrites", nw[0] - nb[0], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
